// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM state
// encoding, request owner, mem_len encoding and the RAM read latency.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // mem_len encoding; both 10 and 11 select a full word
    localparam logic [1:0] LEN_1B     = 2'b00;
    localparam logic [1:0] LEN_2B     = 2'b01;
    localparam logic [1:0] LEN_4B     = 2'b10;
    localparam logic [1:0] LEN_4B_ALT = 2'b11;

    // Instruction fetches are always one full word
    localparam logic [2:0] IF_LEN_BYTES = 3'd4;

    // Cycles from ram_a presented (ram_wr=0) to ram_din valid
    localparam int RAM_RD_LAT = 1;

    // Number of bytes transferred for a given mem_len code
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_1B:  n = 3'd1;
            LEN_2B:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Select byte k of a little-endian 32-bit word
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a
// load/store port onto a single 8-bit synchronous RAM. Each access moves one
// byte per cycle; the owner is acked for one cycle in DONE.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [31:0]       if_data,
    // load/store port
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    // byte RAM
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    localparam logic [2:0] RD_LAT = 3'(RAM_RD_LAT);

    // control state
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    owner_t      owner_q, owner_d;

    // latched request fields (no reset needed, loaded on every grant)
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        len_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;

    // held output data, updated only on an ack
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;

    // grant/capture strobes from the next-state logic
    logic              load;
    logic [ADDR_W-1:0] grant_addr;
    logic [2:0]        grant_len;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [2:0]        last_rd;
    logic [2:0]        rd_idx;

    // Index of the cycle that captures the final read byte
    assign last_rd = len_q + RD_LAT - 3'd1;
    assign rd_idx  = cnt_q - RD_LAT;

    // Arbitration, next state, RAM drive and ack generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        load       = 1'b0;
        grant_addr = mem_addr;
        grant_len  = len_bytes(mem_len);
        cap_en     = 1'b0;
        cap_idx    = 2'd0;
        ram_a      = '0;
        ram_wr     = 1'b0;
        ram_dout   = 8'd0;
        if_ack     = 1'b0;
        mem_ack    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // load/store has fixed priority; a fetch is never granted
                // while a redirect is pending
                if (mem_req) begin
                    load       = 1'b1;
                    grant_addr = mem_addr;
                    grant_len  = len_bytes(mem_len);
                    owner_d    = OWN_MEM;
                    cnt_d      = 3'd0;
                    state_d    = mem_we ? ST_MEM_WR : ST_MEM_RD;
                end else if (if_req && !if_flush) begin
                    load       = 1'b1;
                    grant_addr = if_addr;
                    grant_len  = IF_LEN_BYTES;
                    owner_d    = OWN_IF;
                    cnt_d      = 3'd0;
                    state_d    = ST_IF_RD;
                end
            end

            ST_IF_RD, ST_MEM_RD: begin
                if (state_q == ST_IF_RD && if_flush) begin
                    // redirect abandons the fetch; partial bytes are dropped
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    // address phase for byte cnt, data phase for byte cnt-1
                    if (cnt_q < len_q) begin
                        ram_a = base_q + ADDR_W'(cnt_q);
                    end
                    if (cnt_q >= RD_LAT) begin
                        cap_en  = 1'b1;
                        cap_idx = rd_idx[1:0];
                    end
                    if (cnt_q == last_rd) begin
                        state_d = ST_DONE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_MEM_WR: begin
                ram_a    = base_q + ADDR_W'(cnt_q);
                ram_wr   = 1'b1;
                ram_dout = byte_sel(wdata_q, cnt_q[1:0]);
                if (cnt_q == len_q - 3'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            ST_DONE: begin
                // a late redirect still kills a fetch ack, never a load/store ack
                if (owner_q == OWN_MEM) begin
                    mem_ack = 1'b1;
                end else if (!if_flush) begin
                    if_ack = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // During the ack cycle the freshly assembled word is shown directly;
    // otherwise the value from the last ack is held
    assign if_data   = if_ack ? buf_q : if_data_q;
    assign mem_rdata = (mem_ack && !we_q) ? buf_q : mem_rdata_q;

    // Control state and held output data, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            owner_q     <= OWN_IF;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            if (if_ack) begin
                if_data_q <= buf_q;
            end
            if (mem_ack && !we_q) begin
                mem_rdata_q <= buf_q;
            end
        end
    end

    // Request latch on grant and byte assembly of read data
    always_ff @(posedge clk) begin
        if (load) begin
            base_q  <= grant_addr;
            len_q   <= grant_len;
            we_q    <= mem_req & mem_we;
            wdata_q <= mem_wdata;
            buf_q   <= 32'd0;
        end else if (cap_en) begin
            buf_q[{cap_idx, 3'b000} +: 8] <= ram_din;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    int tests  = 0;
    int failed = 0;
    int if_ack_cnt  = 0;
    int mem_ack_cnt = 0;

    logic [7:0]        ram [0:65535];
    logic [ADDR_W-1:0] addr_log [0:31];
    logic              wr_log   [0:31];

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din)
    );

    always #5 clk = ~clk;

    // RAM model: write on ram_wr, otherwise one-cycle registered read
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        else        ram_din <= ram[ram_a[15:0]];
    end

    // Ack pulse counters
    always @(posedge clk) begin
        if (if_ack)  if_ack_cnt  <= if_ack_cnt + 1;
        if (mem_ack) mem_ack_cnt <= mem_ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance edge by edge, logging RAM drive, until the selected ack is seen;
    // k is the edge count with the grant edge counted as 1 (0 = timeout)
    task automatic wait_ack(input bit is_mem, output int k);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            addr_log[i] = ram_a;
            wr_log[i]   = ram_wr;
            if (is_mem ? mem_ack : if_ack) begin
                k = i;
                break;
            end
        end
    endtask

    // Drop requests after an ack and let the FSM return to IDLE
    task automatic release_req();
        if_req  = 1'b0;
        mem_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int c0;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0200] = 8'h78; ram[16'h0201] = 8'h56; ram[16'h0202] = 8'h34; ram[16'h0203] = 8'h12;
        ram[16'h0300] = 8'hEE; ram[16'h0301] = 8'hEE; ram[16'h0302] = 8'hEE; ram[16'h0303] = 8'hEE;
        ram[16'h1002] = 8'h55;
        ram[16'h2000] = 8'h11; ram[16'h2001] = 8'h22; ram[16'h2002] = 8'h33; ram[16'h2003] = 8'hF0;
        ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB; ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = 2'b00; mem_wdata = '0;

        // reset state
        repeat (3) step();
        check("rst_if_ack",    64'(if_ack),    64'd0);
        check("rst_mem_ack",   64'(mem_ack),   64'd0);
        check("rst_ram_wr",    64'(ram_wr),    64'd0);
        check("rst_ram_a",     64'(ram_a),     64'd0);
        check("rst_if_data",   64'(if_data),   64'd0);
        check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
        check("rst_state",     64'(dut.state_q), 64'(ST_IDLE));
        rst = 1'b0;
        step();

        // instruction fetch at 0x100
        if_addr = 32'h100; if_req = 1'b1;
        wait_ack(1'b0, k);
        check("if_lat",    64'(k), 64'd6);
        check("if_a0",     64'(addr_log[1]), 64'h100);
        check("if_a1",     64'(addr_log[2]), 64'h101);
        check("if_a3",     64'(addr_log[4]), 64'h103);
        check("if_wr",     64'(wr_log[2]), 64'd0);
        check("if_data",   64'(if_data), 64'h0000_0513);
        release_req();
        step();
        check("if_hold",   64'(if_data), 64'h0000_0513);
        check("idle_ram_a", 64'(ram_a), 64'd0);

        // simultaneous requests: store of two bytes wins, fetch follows
        if_addr = 32'h100; if_req = 1'b1;
        mem_we = 1'b1; mem_len = 2'b01; mem_addr = 32'h1000; mem_wdata = 32'h0000_ABCD; mem_req = 1'b1;
        wait_ack(1'b1, k);
        check("st_lat",    64'(k), 64'd3);
        check("st_wr0",    64'(wr_log[1]), 64'd1);
        check("st_a0",     64'(addr_log[1]), 64'h1000);
        check("st_a1",     64'(addr_log[2]), 64'h1001);
        mem_req = 1'b0;
        wait_ack(1'b0, k);
        check("if2_lat",   64'(k), 64'd7);
        check("if2_data",  64'(if_data), 64'h0000_0513);
        release_req();
        check("st_b0",     64'(ram[16'h1000]), 64'hCD);
        check("st_b1",     64'(ram[16'h1001]), 64'hAB);
        check("st_b2",     64'(ram[16'h1002]), 64'h55);
        check("idle_ram_wr", 64'(ram_wr), 64'd0);

        // loads of 4, 2 and 1 bytes
        mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h2000; mem_req = 1'b1;
        wait_ack(1'b1, k);
        check("ld4_lat",   64'(k), 64'd6);
        check("ld4_data",  64'(mem_rdata), 64'hF033_2211);
        release_req();
        mem_len = 2'b01; mem_addr = 32'h2001; mem_req = 1'b1;
        wait_ack(1'b1, k);
        check("ld2_lat",   64'(k), 64'd4);
        check("ld2_data",  64'(mem_rdata), 64'h0000_3322);
        release_req();
        mem_len = 2'b00; mem_addr = 32'h2003; mem_req = 1'b1;
        wait_ack(1'b1, k);
        check("ld1_lat",   64'(k), 64'd3);
        check("ld1_data",  64'(mem_rdata), 64'h0000_00F0);
        release_req();

        // word load wrapping past the top of the address space
        mem_len = 2'b11; mem_addr = 32'hFFFF_FFFE; mem_req = 1'b1;
        wait_ack(1'b1, k);
        check("wrap_lat",  64'(k), 64'd6);
        check("wrap_a1",   64'(addr_log[2]), 64'hFFFF_FFFF);
        check("wrap_a2",   64'(addr_log[3]), 64'h0);
        check("wrap_data", 64'(mem_rdata), 64'hDDCC_BBAA);
        release_req();

        // redirect during a fetch: no ack, back to IDLE, next fetch granted
        c0 = if_ack_cnt;
        if_addr = 32'h300; if_req = 1'b1;
        repeat (4) step();
        if_flush = 1'b1;
        step();
        check("fl_state",  64'(dut.state_q), 64'(ST_IDLE));
        check("fl_noack",  64'(if_ack_cnt - c0), 64'd0);
        if_flush = 1'b0; if_addr = 32'h200;
        wait_ack(1'b0, k);
        check("fl_lat",    64'(k), 64'd6);
        check("fl_data",   64'(if_data), 64'h1234_5678);
        release_req();

        // redirect in DONE suppresses the fetch ack and blocks re-grant in IDLE
        c0 = if_ack_cnt;
        if_addr = 32'h100; if_req = 1'b1;
        repeat (6) step();
        check("fd_state",  64'(dut.state_q), 64'(ST_DONE));
        if_flush = 1'b1;
        #1;
        check("fd_ack",    64'(if_ack), 64'd0);
        check("fd_hold",   64'(if_data), 64'h1234_5678);
        step();
        step();
        check("fd_nogrant", 64'(dut.state_q), 64'(ST_IDLE));
        if_flush = 1'b0; if_req = 1'b0;
        step();
        check("fd_noack",  64'(if_ack_cnt - c0), 64'd0);

        // redirect has no effect on a load
        if_flush = 1'b1;
        mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h2000; mem_req = 1'b1;
        wait_ack(1'b1, k);
        check("mfl_lat",   64'(k), 64'd6);
        check("mfl_data",  64'(mem_rdata), 64'hF033_2211);
        release_req();
        if_flush = 1'b0;

        // reset in the middle of a word store
        c0 = mem_ack_cnt;
        mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'h4433_2211; mem_req = 1'b1;
        repeat (3) step();
        check("rs_a2",     64'(ram_a), 64'h3002);
        check("rs_wr2",    64'(ram_wr), 64'd1);
        rst = 1'b1; mem_req = 1'b0;
        step();
        check("rs_wr",     64'(ram_wr), 64'd0);
        check("rs_state",  64'(dut.state_q), 64'(ST_IDLE));
        check("rs_ack",    64'(mem_ack), 64'd0);
        check("rs_if_data",   64'(if_data), 64'd0);
        check("rs_mem_rdata", 64'(mem_rdata), 64'd0);
        rst = 1'b0;
        repeat (3) step();
        check("rs_noack",  64'(mem_ack_cnt - c0), 64'd0);
        check("rs_b0",     64'(ram[16'h3000]), 64'h11);
        check("rs_b1",     64'(ram[16'h3001]), 64'h22);
        check("rs_b3",     64'(ram[16'h3003]), 64'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of all byte addresses.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  fetch request; held until if_ack.
REQ-005 if_addr  in  ADDR_W  fetch byte address; stable while if_req high.
REQ-006 if_flush  in  1  branch redirect; cancels an in-flight fetch.
REQ-007 if_ack  out  1  one-cycle pulse; if_data valid.
REQ-008 if_data  out  32  fetched instruction, little-endian.
REQ-009 mem_req  in  1  load/store request; held until mem_ack.
REQ-010 mem_we  in  1  1 = store, 0 = load.
REQ-011 mem_addr  in  ADDR_W  load/store base byte address.
REQ-012 mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
REQ-013 mem_wdata  in  32  store data; byte k is bits [8k+7:8k].
REQ-014 mem_ack  out  1  one-cycle pulse; load data valid or store complete.
REQ-015 mem_rdata  out  32  load data, zero-extended above mem_len bytes.
REQ-016 ram_a  out  ADDR_W  RAM byte address.
REQ-017 ram_wr  out  1  RAM write enable.
REQ-018 ram_dout  out  8  RAM write byte.
REQ-019 ram_din  in  8  RAM read byte; valid the cycle after ram_a is presented with ram_wr=0.

Function
REQ-020 The FSM SHALL have states IDLE, IF_RD, MEM_RD, MEM_WR, DONE, plus a 3-bit byte counter c and a latched owner (IF/MEM).
REQ-021 In IDLE, the controller SHALL grant mem_req over if_req (fixed priority); if_req SHALL NOT be granted in a cycle where if_flush=1.
REQ-022 On grant, the controller SHALL latch address, length (IF = 4), we and wdata; next state SHALL be IF_RD, MEM_RD or MEM_WR with c=0.
REQ-023 In read states with c<n, the controller SHALL drive ram_a=base+c (mod 2^ADDR_W), ram_wr=0; when c>=1 it SHALL capture ram_din into byte c-1; at c==n it SHALL capture byte n-1 and go to DONE.
REQ-024 In MEM_WR, the controller SHALL drive ram_a=base+c, ram_wr=1, ram_dout=wdata byte c for c=0..n-1, then go to DONE.
REQ-025 In DONE, the controller SHALL assert the owner's ack for exactly one cycle with data, then go to IDLE.
REQ-026 Latency from grant edge T (request sampled in IDLE): read ack at T+n+2 (IF: T+6), store ack at T+n+1.
REQ-027 Requesters SHALL deassert req in the cycle after ack; the controller SHALL NOT re-grant in DONE.
REQ-028 if_flush in IF_RD SHALL return the FSM to IDLE next cycle with no if_ack; if_flush in DONE with owner IF SHALL suppress if_ack.
REQ-029 if_flush SHALL NOT affect MEM_RD, MEM_WR or a MEM-owned DONE.
REQ-030 Outside MEM_WR, ram_wr SHALL be 0; in IDLE, ram_a SHALL be 0.
REQ-031 if_data and mem_rdata SHALL hold their last values between acks.

Reset
REQ-032 On rst, the FSM SHALL enter IDLE with c=0; if_ack=0, mem_ack=0, ram_wr=0, if_data=0 and mem_rdata=0 in the following cycle.
REQ-033 rst mid-access SHALL discard partial data, emit no ack, and abandon a partial store (bytes already written remain written).

Structure
REQ-034 The shared defines package SHALL hold the state encoding, the mem_len encoding and the RAM read latency (1).
REQ-035 The block SHALL be a single module with no sub-module; arbitration is inline in IDLE.

Verification
REQ-036 IF read at 0x100, RAM bytes 13,05,00,00: ram_a 0x100..0x103 on T+1..T+4, if_ack at T+6, if_data=0x00000513.
REQ-037 if_req and mem_req (store, len=01, addr 0x1000, wdata 0x0000ABCD) raised together: MEM wins; writes CD to 0x1000 and AB to 0x1001; mem_ack at T+3; IF granted afterwards.
REQ-038 Load len=00 at 0x2003, RAM byte 0xF0: mem_rdata=0x000000F0.
REQ-039 if_flush at T+3 of an IF read: no if_ack; IDLE at T+4; new if_req at 0x200 is granted next.
REQ-040 if_flush during a MEM_RD: access completes, mem_ack delivered.
REQ-041 rst at c=2 of a 4-byte store: ram_wr=0 next cycle, no mem_ack, FSM in IDLE.
